motion_cmd_decoder: RTL and testbench

Upstream stage of the motor PWM driver. It decodes single-byte ASCII drive commands from the Bluetooth UART receiver into the level signals the driver consumes: `forward`, `back`, `turn`, `start2`, plus steering direction. It enforces a dead-time on every forward/reverse change so the H-bridge never reverses instantly. A watchdog stops the car when the command link goes silent.

---
 rtl/car_cmd_pkg.sv | 42 ++++
 rtl/cycle_timer.sv | 41 ++++
 rtl/motion_cmd_decoder.sv | 179 +++++++++++++++++
 tb/tb_motion_cmd_decoder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/car_cmd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : car_cmd_pkg
//  Purpose  : Shared definitions for the motion command decoder. Holds the
//             ASCII command byte values, the drive state encoding, the
//             dead-time target type and a recogniser for the command set.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package car_cmd_pkg;

  localparam logic [7:0] CMD_GO     = 8'h47;  // 'G'
  localparam logic [7:0] CMD_DISARM = 8'h58;  // 'X'
  localparam logic [7:0] CMD_FWD    = 8'h46;  // 'F'
  localparam logic [7:0] CMD_BACK   = 8'h42;  // 'B'
  localparam logic [7:0] CMD_STOP   = 8'h53;  // 'S'
  localparam logic [7:0] CMD_LEFT   = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RIGHT  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_CENTRE = 8'h43;  // 'C'

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2,
    DEAD = 2'd3
  } drive_state_t;

  typedef enum logic {
    TGT_FWD = 1'b0,
    TGT_REV = 1'b1
  } dead_target_t;

  // True for any byte belonging to the command set, armed or not.
  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_GO)   || (b == CMD_DISARM) || (b == CMD_FWD)   ||
           (b == CMD_BACK) || (b == CMD_STOP)   || (b == CMD_LEFT)  ||
           (b == CMD_RIGHT)|| (b == CMD_CENTRE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cycle_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cycle_timer
//  Purpose  : Saturating cycle counter. Counts up while en, clears on clr
//             (clr wins), and stops at N. done is high while the count
//             equals N-1; because the count moves past N-1 and parks at N,
//             done is high for a single cycle per run.
//  Ports    : clk, rst_n (sync, active-low), clr, en -> done
//  Revision : 1.0  initial release
// ============================================================================
module cycle_timer #(
  parameter int N = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int         CW   = $clog2(N + 1);
  localparam logic [CW-1:0] C_MAX  = CW'(N);
  localparam logic [CW-1:0] C_TERM = CW'(N - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != C_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == C_TERM);

endmodule
`default_nettype wire

// File: rtl/motion_cmd_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : motion_cmd_decoder
//  Purpose  : Decodes single-byte ASCII drive commands into registered level
//             signals for the PWM motor driver. Forces a coast interval on
//             every forward/reverse change and stops the car when the
//             command link goes silent.
//  Ports    : clk, rst_n (sync, active-low)
//             rx_data[7:0], rx_valid           : byte stream from UART
//             forward, back, turn              : drive levels
//             steer_left, steer_right, start2  : steering / armed
//             cmd_err, wdog_trip               : one-cycle event pulses
//  Revision : 1.0  initial release
// ============================================================================
module motion_cmd_decoder
  import car_cmd_pkg::*;
#(
  parameter int WDOG_CYCLES = 50_000_000,
  parameter int DEAD_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       forward,
  output logic       back,
  output logic       turn,
  output logic       steer_left,
  output logic       steer_right,
  output logic       start2,
  output logic       cmd_err,
  output logic       wdog_trip
);

  drive_state_t state, next_state;
  dead_target_t target, next_target;

  logic next_start2, next_turn, next_left, next_right;
  logic next_err, next_trip;
  logic known_cmd;
  logic wdog_done, dead_done;

  assign known_cmd = rx_valid && is_cmd(rx_data);

  // Watchdog: any recognised byte (even one ignored while disarmed) counts
  // as link activity.
  cycle_timer #(.N(WDOG_CYCLES)) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (known_cmd),
    .en    (1'b1),
    .done  (wdog_done)
  );

  // Dead-time: held clear outside DEAD, so it starts from zero on entry and
  // a target change while in DEAD does not restart it.
  cycle_timer #(.N(DEAD_CYCLES)) u_dead (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != DEAD),
    .en    (state == DEAD),
    .done  (dead_done)
  );

  always_comb begin
    next_state  = state;
    next_target = target;
    next_start2 = start2;
    next_turn   = turn;
    next_left   = steer_left;
    next_right  = steer_right;
    next_err    = 1'b0;
    next_trip   = 1'b0;

    if (rx_valid) begin
      if (!known_cmd) begin
        next_err = 1'b1;
      end else begin
        case (rx_data)
          CMD_GO: next_start2 = 1'b1;
          CMD_DISARM: begin
            next_start2 = 1'b0;
            next_state  = IDLE;
            next_turn   = 1'b0;
            next_left   = 1'b0;
            next_right  = 1'b0;
          end
          CMD_STOP: next_state = IDLE;
          CMD_CENTRE: begin
            next_turn  = 1'b0;
            next_left  = 1'b0;
            next_right = 1'b0;
          end
          CMD_FWD: begin
            if (start2) begin
              case (state)
                IDLE: next_state = FWD;
                REV: begin
                  next_state  = DEAD;
                  next_target = TGT_FWD;
                end
                DEAD: next_target = TGT_FWD;
                default: ;
              endcase
            end
          end
          CMD_BACK: begin
            if (start2) begin
              case (state)
                IDLE: next_state = REV;
                FWD: begin
                  next_state  = DEAD;
                  next_target = TGT_REV;
                end
                DEAD: next_target = TGT_REV;
                default: ;
              endcase
            end
          end
          CMD_LEFT: begin
            if (start2) begin
              next_turn  = 1'b1;
              next_left  = 1'b1;
              next_right = 1'b0;
            end
          end
          CMD_RIGHT: begin
            if (start2) begin
              next_turn  = 1'b1;
              next_left  = 1'b0;
              next_right = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end else if (wdog_done) begin
      next_state = IDLE;
      next_turn  = 1'b0;
      next_left  = 1'b0;
      next_right = 1'b0;
      next_trip  = 1'b1;
    end

    // Dead interval expiry; a stop/disarm/trip this cycle already chose IDLE.
    if ((state == DEAD) && (next_state == DEAD) && dead_done) begin
      next_state = (next_target == TGT_FWD) ? FWD : REV;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      target      <= TGT_FWD;
      forward     <= 1'b0;
      back        <= 1'b0;
      turn        <= 1'b0;
      steer_left  <= 1'b0;
      steer_right <= 1'b0;
      start2      <= 1'b0;
      cmd_err     <= 1'b0;
      wdog_trip   <= 1'b0;
    end else begin
      state       <= next_state;
      target      <= next_target;
      forward     <= (next_state == FWD);
      back        <= (next_state == REV);
      turn        <= next_turn;
      steer_left  <= next_left;
      steer_right <= next_right;
      start2      <= next_start2;
      cmd_err     <= next_err;
      wdog_trip   <= next_trip;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_motion_cmd_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_motion_cmd_decoder
//  Purpose  : Scoreboard bench for motion_cmd_decoder. A behavioural model
//             predicts the output vector for every clock edge and queues it;
//             an independent monitor pops and compares after each edge.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_motion_cmd_decoder;

  localparam int W = 100;
  localparam int D = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       forward, back, turn, steer_left, steer_right, start2;
  logic       cmd_err, wdog_trip;

  motion_cmd_decoder #(.WDOG_CYCLES(W), .DEAD_CYCLES(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .forward     (forward),
    .back        (back),
    .turn        (turn),
    .steer_left  (steer_left),
    .steer_right (steer_right),
    .start2      (start2),
    .cmd_err     (cmd_err),
    .wdog_trip   (wdog_trip)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int edge_no = 0;
  logic [7:0] exp_q[$];

  // ---------------- reference model ----------------
  // mode: 0 stopped, 1 forward, 2 reverse, 3 coasting before a reversal
  int m_mode, m_tgt, m_spent, m_since;
  bit m_armed, m_turn, m_l, m_r;

  function automatic bit known(input logic [7:0] b);
    return b inside {8'h47, 8'h58, 8'h46, 8'h42, 8'h53, 8'h4C, 8'h52, 8'h43};
  endfunction

  task automatic model_step(input bit r, input bit v, input logic [7:0] d);
    bit err, trip;
    int prev;
    err = 0; trip = 0;
    if (!r) begin
      m_mode = 0; m_tgt = 1; m_spent = 0; m_since = 0;
      m_armed = 0; m_turn = 0; m_l = 0; m_r = 0;
    end else begin
      prev = m_mode;
      if (v && known(d)) begin
        m_since = 0;
        case (d)
          8'h47: m_armed = 1;
          8'h58: begin m_armed = 0; m_mode = 0; m_turn = 0; m_l = 0; m_r = 0; end
          8'h53: m_mode = 0;
          8'h43: begin m_turn = 0; m_l = 0; m_r = 0; end
          8'h46: if (m_armed) begin
                   if (m_mode == 0) m_mode = 1;
                   else if (m_mode == 2) begin m_mode = 3; m_tgt = 1; end
                   else if (m_mode == 3) m_tgt = 1;
                 end
          8'h42: if (m_armed) begin
                   if (m_mode == 0) m_mode = 2;
                   else if (m_mode == 1) begin m_mode = 3; m_tgt = 2; end
                   else if (m_mode == 3) m_tgt = 2;
                 end
          8'h4C: if (m_armed) begin m_turn = 1; m_l = 1; m_r = 0; end
          8'h52: if (m_armed) begin m_turn = 1; m_l = 0; m_r = 1; end
          default: ;
        endcase
      end else begin
        if (v) err = 1;
        else if (m_since == W - 1) begin
          trip = 1; m_mode = 0; m_turn = 0; m_l = 0; m_r = 0;
        end
        if (m_since < W) m_since++;
      end
      if (prev != 3 && m_mode == 3) m_spent = 0;
      else if (prev == 3 && m_mode == 3) begin
        m_spent++;
        if (m_spent == D) m_mode = m_tgt;
      end
    end
    exp_q.push_back({m_mode == 1, m_mode == 2, m_turn, m_l, m_r,
                     (r ? m_armed : 1'b0), err, trip});
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit r, input bit v, input logic [7:0] d);
    @(negedge clk);
    rst_n = r; rx_valid = v; rx_data = d;
    model_step(r, v, d);
  endtask

  task automatic send(input logic [7:0] d);
    drive(1, 1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, $urandom_range(0, 255));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 8'h00);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [7:0] act, e;
    #1;
    edge_no++;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {forward, back, turn, steer_left, steer_right, start2, cmd_err, wdog_trip};
      checks++;
      if (act === e) passed++;
      else $display("FAIL outputs edge %0d: got %b expected %b (fwd,back,turn,l,r,start2,err,trip)",
                    edge_no, act, e);
      checks++;
      if (!(forward === 1'b1 && back === 1'b1)) passed++;
      else $display("FAIL fwd_back_exclusive edge %0d: got forward=1 back=1 expected not both", edge_no);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] cmds [8] = '{8'h47, 8'h58, 8'h46, 8'h42, 8'h53, 8'h4C, 8'h52, 8'h43};
    logic [7:0] b;

    // reset, then silence long enough for the post-reset trip
    do_reset(3);
    idle(105);

    // arm, forward, reverse through dead-time
    send(8'h47); send(8'h46); idle(3);
    send(8'h42); idle(D + 3);
    // forward->reverse, then retarget to forward mid-dead
    send(8'h46); idle(3);
    send(8'h42); idle(4); send(8'h46); idle(D + 2);
    send(8'h53); idle(2);

    // turning then silence -> watchdog trip, start2 kept
    send(8'h46); send(8'h4C); idle(W + 5);

    // disarmed: invalid byte errors, 'F' silently ignored
    send(8'h58); send(8'h41); idle(2); send(8'h46); idle(3);

    // reset in the middle of the dead interval, then immediate reverse
    send(8'h47); send(8'h46); send(8'h42); idle(3);
    do_reset(1);
    send(8'h47); send(8'h42); idle(3);

    // randomized traffic
    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 49) == 0) do_reset($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) b = 8'($urandom_range(0, 255));
      else if ($urandom_range(0, 3) == 0) b = 8'h47;
      else b = cmds[$urandom_range(0, 7)];
      send(b);
      if ($urandom_range(0, 19) == 0) idle($urandom_range(95, 110));
      else idle($urandom_range(0, 14));
    end

    idle(2);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
